// File: rtl/scoreboard_reg_file.sv
// scoreboard_reg_file: register file with per-register dirty bits, serving one
// check/read/write/lock request per transaction plus an always-on writeback port.
module scoreboard_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int CMD_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            i_reg,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CMD_WIDTH-1:0]  i_cmd,
    input  logic                  i_valid,
    input  logic                  i_res_ready,
    input  logic                  i_wb_valid,
    input  logic [3:0]            i_wb_reg,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_res_valid,
    output logic                  o_ready
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t                state, next;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   dirty;
    logic                  accept, is_read, is_write, is_lock;
    logic [DATA_WIDTH-1:0] resp;

    always_comb begin
        next     = state;
        o_ready  = state == IDLE;
        o_res_valid = state == RESP;
        accept   = o_ready && i_valid;
        // any command value other than READ/WRITE/LOCK falls through to CHECK
        is_read  = i_cmd == CMD_WIDTH'(1);
        is_write = i_cmd == CMD_WIDTH'(2);
        is_lock  = i_cmd == CMD_WIDTH'(3);
        resp     = is_write ? i_data : is_read ? regs[i_reg] : DATA_WIDTH'(dirty[i_reg]);
        next     = (state == IDLE) ? (accept ? RESP : IDLE) : (i_res_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // request-port updates come after writeback so they win on a shared index
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            dirty  <= '0;
            o_data <= '0;
        end else begin
            if (i_wb_valid) begin
                regs[i_wb_reg]  <= i_wb_data;
                dirty[i_wb_reg] <= 1'b0;
            end
            if (accept && is_write) begin
                regs[i_reg]  <= i_data;
                dirty[i_reg] <= 1'b0;
            end
            if (accept && is_lock) dirty[i_reg] <= 1'b1;
            if (accept) o_data <= resp;
        end
    end
endmodule

// File: tb/tb_scoreboard_reg_file.sv
// tb_scoreboard_reg_file: directed vector table, corner-case sequences and
// randomized transactions checked against an array-based model.
module tb_scoreboard_reg_file;
    logic        clk = 0;
    logic        reset;
    logic [3:0]  i_reg, i_wb_reg;
    logic [31:0] i_data, i_wb_data, o_data;
    logic [1:0]  i_cmd;
    logic        i_valid, i_res_ready, i_wb_valid, o_res_valid, o_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [16];
    logic        m_dirty [16];

    typedef struct {
        logic [1:0]  c;
        logic [3:0]  r;
        logic [31:0] d;
        logic        wv;
        logic [3:0]  wr;
        logic [31:0] wd;
        logic [31:0] e;
    } vec_t;

    vec_t tbl[$];

    scoreboard_reg_file #(.DATA_WIDTH(32), .NUM_REGS(16), .CMD_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .i_reg(i_reg), .i_data(i_data), .i_cmd(i_cmd),
        .i_valid(i_valid), .i_res_ready(i_res_ready), .i_wb_valid(i_wb_valid),
        .i_wb_reg(i_wb_reg), .i_wb_data(i_wb_data), .o_data(o_data),
        .o_res_valid(o_res_valid), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_regs[i]  = 0;
            m_dirty[i] = 0;
        end
    endtask

    function automatic logic [31:0] m_resp(input logic [1:0] c, input logic [3:0] r, input logic [31:0] d);
        return c == 1 ? m_regs[r] : c == 2 ? d : c == 3 ? {31'b0, m_dirty[r]} : {31'b0, m_dirty[r]};
    endfunction

    task automatic m_wb(input logic [3:0] r, input logic [31:0] d);
        m_regs[r]  = d;
        m_dirty[r] = 0;
    endtask

    // one accepted request: writeback first, then the request's own effect
    task automatic m_step(input logic [1:0] c, input logic [3:0] r, input logic [31:0] d,
                          input logic wv, input logic [3:0] wr, input logic [31:0] wd);
        if (wv) m_wb(wr, wd);
        if (c == 2) begin
            m_regs[r]  = d;
            m_dirty[r] = 0;
        end
        if (c == 3) m_dirty[r] = 1;
    endtask

    // starts and ends on a falling edge with the DUT idle
    task automatic txn(input string nm, input logic [1:0] c, input logic [3:0] r, input logic [31:0] d,
                       input logic wv, input logic [3:0] wr, input logic [31:0] wd,
                       input int hold, input bit rnd, input logic [31:0] exp);
        chk({nm, "_ready_idle"}, {31'b0, o_ready}, 1);
        i_valid = 1; i_cmd = c; i_reg = r; i_data = d;
        i_wb_valid = wv; i_wb_reg = wr; i_wb_data = wd; i_res_ready = 1;
        m_step(c, r, d, wv, wr, wd);
        @(negedge clk);
        chk({nm, "_resvalid"}, {31'b0, o_res_valid}, 1);
        chk({nm, "_data"}, o_data, exp);
        chk({nm, "_ready_busy"}, {31'b0, o_ready}, 0);
        i_wb_valid = 0;
        if (rnd && $urandom_range(1) == 1) begin
            i_wb_valid = 1; i_wb_reg = 4'($urandom_range(3)); i_wb_data = $urandom;
            m_wb(i_wb_reg, i_wb_data);
        end
        if (hold > 0) begin
            i_res_ready = 0; i_cmd = 2; i_data = ~d;
        end else i_valid = 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            i_wb_valid = 0;
            chk({nm, "_hold_valid"}, {31'b0, o_res_valid}, 1);
            chk({nm, "_hold_data"}, o_data, exp);
            chk({nm, "_hold_ready"}, {31'b0, o_ready}, 0);
            if (k == hold - 1) begin
                i_res_ready = 1; i_valid = 0;
            end
        end
        @(negedge clk);
        i_wb_valid = 0;
        chk({nm, "_done_valid"}, {31'b0, o_res_valid}, 0);
        chk({nm, "_done_ready"}, {31'b0, o_ready}, 1);
    endtask

    task automatic wb_only(input logic [3:0] r, input logic [31:0] d);
        i_wb_valid = 1; i_wb_reg = r; i_wb_data = d;
        m_wb(r, d);
        @(negedge clk);
        i_wb_valid = 0;
    endtask

    initial begin
        logic [1:0]  c;
        logic [3:0]  r, wr;
        logic [31:0] d, wd;
        logic        wv;
        tbl.push_back('{2'd0, 4'd3,  32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd2, 4'd5,  32'hDEADBEEF, 1'b0, 4'd0, 32'h0,    32'hDEADBEEF});
        tbl.push_back('{2'd1, 4'd5,  32'h0,        1'b0, 4'd0, 32'h0,    32'hDEADBEEF});
        tbl.push_back('{2'd0, 4'd5,  32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd3, 4'd2,  32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd0, 4'd2,  32'h0,        1'b0, 4'd0, 32'h0,    32'h1});
        tbl.push_back('{2'd0, 4'd3,  32'h0,        1'b1, 4'd2, 32'h1234, 32'h0});
        tbl.push_back('{2'd0, 4'd2,  32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd1, 4'd2,  32'h0,        1'b0, 4'd0, 32'h0,    32'h1234});
        tbl.push_back('{2'd3, 4'd7,  32'h0,        1'b1, 4'd7, 32'h55,   32'h0});
        tbl.push_back('{2'd0, 4'd7,  32'h0,        1'b0, 4'd0, 32'h0,    32'h1});
        tbl.push_back('{2'd1, 4'd7,  32'h0,        1'b0, 4'd0, 32'h0,    32'h55});
        tbl.push_back('{2'd2, 4'd7,  32'hAA,       1'b1, 4'd7, 32'h55,   32'hAA});
        tbl.push_back('{2'd1, 4'd7,  32'h0,        1'b0, 4'd0, 32'h0,    32'hAA});
        tbl.push_back('{2'd0, 4'd7,  32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd3, 4'd7,  32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd0, 4'd7,  32'h0,        1'b1, 4'd7, 32'h99,   32'h1});
        tbl.push_back('{2'd0, 4'd7,  32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd1, 4'd7,  32'h0,        1'b1, 4'd7, 32'h77,   32'h99});
        tbl.push_back('{2'd1, 4'd7,  32'h0,        1'b0, 4'd0, 32'h0,    32'h77});
        tbl.push_back('{2'd3, 4'd2,  32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd3, 4'd2,  32'h0,        1'b0, 4'd0, 32'h0,    32'h1});
        tbl.push_back('{2'd2, 4'd2,  32'h5,        1'b0, 4'd0, 32'h0,    32'h5});
        tbl.push_back('{2'd0, 4'd2,  32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd1, 4'd15, 32'h0,        1'b0, 4'd0, 32'h0,    32'h0});
        tbl.push_back('{2'd2, 4'd0,  32'hCAFE,     1'b0, 4'd0, 32'h0,    32'hCAFE});
        tbl.push_back('{2'd1, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,    32'hCAFE});

        reset = 1; i_valid = 0; i_res_ready = 0; i_wb_valid = 0;
        i_reg = 0; i_data = 0; i_cmd = 0; i_wb_reg = 0; i_wb_data = 0;
        m_clear();
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'b0, o_ready}, 1);
        chk("reset_resvalid", {31'b0, o_res_valid}, 0);
        chk("reset_data", o_data, 0);
        reset = 0;

        foreach (tbl[i])
            txn($sformatf("vec%0d", i), tbl[i].c, tbl[i].r, tbl[i].d,
                tbl[i].wv, tbl[i].wr, tbl[i].wd, 0, 0, tbl[i].e);

        // stalled response with a second request held on the port
        txn("stall_read", 2'd1, 4'd5, 32'h0, 0, 0, 0, 4, 0, 32'hDEADBEEF);
        txn("after_stall", 2'd1, 4'd5, 32'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF);

        // a lone writeback is visible to the very next request
        wb_only(4'd9, 32'h4242);
        txn("wb_visible", 2'd1, 4'd9, 32'h0, 0, 0, 0, 0, 0, 32'h4242);

        // reset while the LOCK response is pending
        i_valid = 1; i_cmd = 3; i_reg = 1; i_res_ready = 0;
        @(negedge clk);
        chk("rst_mid_resvalid", {31'b0, o_res_valid}, 1);
        i_valid = 0; reset = 1;
        @(negedge clk);
        chk("rst_mid_dropped", {31'b0, o_res_valid}, 0);
        chk("rst_mid_ready", {31'b0, o_ready}, 1);
        chk("rst_mid_data", o_data, 0);
        reset = 0;
        m_clear();
        txn("rst_check_r1", 2'd0, 4'd1, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        txn("rst_read_r1", 2'd1, 4'd1, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        txn("rst_read_r5", 2'd1, 4'd5, 32'h0, 0, 0, 0, 0, 0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) wb_only(4'($urandom_range(3)), $urandom);
            else begin
                c  = 2'($urandom_range(3));
                r  = 4'($urandom_range(3));
                d  = $urandom;
                wv = 1'($urandom_range(1));
                wr = $urandom_range(1) == 1 ? r : 4'($urandom_range(3));
                wd = $urandom;
                txn($sformatf("rnd%0d", n), c, r, d, wv, wr, wd, $urandom_range(2), 1, m_resp(c, r, d));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scoreboard_reg_file.md
# scoreboard_reg_file

Architectural register file with per-register dirty (scoreboard) bits. It is the responder end of the request/response register protocol that the operand-fetch (memory) stage drives. It serves one command per transaction (check, read, write, lock) and returns a registered response. A separate writeback port retires results into the file and clears their dirty bits.

## Interface
Parameters:
- DATA_WIDTH, default 32, register and data width (matches `DATA_WIDTH)
- NUM_REGS, default 16, number of registers (index width fixed at 4)
- CMD_WIDTH, default 2, command width (matches `REG_CMD_WIDTH)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- i_reg  in  4  register index for the request
- i_data  in  DATA_WIDTH  write data for REG_CMD_WRITE
- i_cmd  in  CMD_WIDTH  command: CHECK=0, READ=1, WRITE=2, LOCK=3 (`REG_CMD_* macros)
- i_valid  in  1  request valid
- i_res_ready  in  1  requester can accept the response
- i_wb_valid  in  1  writeback strobe
- i_wb_reg  in  4  writeback register index
- i_wb_data  in  DATA_WIDTH  writeback data
- o_data  out  DATA_WIDTH  response data
- o_res_valid  out  1  response valid
- o_ready  out  1  block can accept a request

## Operation
- Storage: regs[0..15] of DATA_WIDTH bits and dirty[0..15]. All 16 entries are writable; there is no hardwired zero.
- FSM has two states.
  - IDLE: o_ready=1, o_res_valid=0. Accept when i_valid && o_ready. On acceptance, execute the command, latch the response into o_data, go to RESP.
  - RESP: o_ready=0, o_res_valid=1, o_data held stable. Go to IDLE on the cycle i_res_ready=1.
- Commands, executed in the acceptance cycle:
  - CHECK: o_data = zero-extended dirty[i_reg]. Non-zero means the register is busy.
  - READ: o_data = regs[i_reg]. Dirty state is not consulted; the requester checks first.
  - WRITE: regs[i_reg] <= i_data, dirty[i_reg] <= 0; o_data = i_data.
  - LOCK: dirty[i_reg] <= 1; o_data = zero-extended previous dirty[i_reg].
- Writeback port acts every cycle, in any FSM state: when i_wb_valid=1, regs[i_wb_reg] <= i_wb_data and dirty[i_wb_reg] <= 0.
- Same-cycle conflicts on the same index:
  - WRITE + writeback: the request port wins for both data and dirty.
  - LOCK + writeback: data takes the writeback value; dirty ends at 1.
  - CHECK/READ + writeback: the response reflects pre-edge state (old value / old dirty). There is no bypass.
- Requests arriving while in RESP are ignored (o_ready=0). The requester must hold i_valid until it sees o_res_valid.

## Timing
- Reset values: o_ready=1, o_res_valid=0, o_data=0, all regs=0, all dirty=0, FSM=IDLE.
- Reset mid-transaction (in RESP) drops the pending response. The next cycle is IDLE with o_res_valid=0.
- Latency: request accepted at edge N; o_res_valid=1 and o_data valid after edge N, i.e. during cycle N+1.
- A response is consumed at the first edge where o_res_valid && i_res_ready. o_res_valid falls after that edge and o_ready rises in the same cycle.
- Throughput is at most one transaction per 2 cycles: one bubble cycle in IDLE between responses.
- If i_res_ready is already high when the response appears, the response lasts exactly one cycle.
- Writeback write and dirty clear are visible to a request accepted in the cycle after i_wb_valid.
- An out-of-range CMD value (CMD_WIDTH>2) is treated as CHECK.

## Test plan
- Reset then CHECK r3 with i_res_ready=1 -> o_ready=1 post-reset; o_res_valid high for one cycle, one cycle after acceptance, with o_data=0.
- WRITE r5=0xDEADBEEF, then READ r5 -> the second response o_data=0xDEADBEEF; a following CHECK r5 returns 0.
- LOCK r2 -> response 0; CHECK r2 -> 1; writeback r2=0x1234 -> next CHECK r2 returns 0 and READ r2 returns 0x1234.
- Hold i_res_ready=0 for 4 cycles after a READ -> o_res_valid and o_data stay stable, o_ready=0, and a second i_valid request is not executed; raise i_res_ready -> back to IDLE.
- Same-cycle LOCK r7 and writeback r7=0x55 -> dirty[7]=1 and regs[7]=0x55. Same-cycle WRITE r7=0xAA and writeback r7=0x55 -> regs[7]=0xAA.
- Assert reset while in RESP after LOCK r1 -> o_res_valid=0 next cycle, dirty[1]=0, READ r1 returns 0.
